// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared definitions for the N-master to 1-slave memory bus arbiter:
//   FSM state encodings and arbitration mode codes used by bus_arbiter
//   and bus_arb_picker.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

// File: rtl/bus_arb_picker.sv
// bus_arb_picker
//   Combinational winner selection for the bus arbiter.
//   Ports:
//     req        in   NUM_MASTERS  request vector
//     last_grant in   IDX_W        index of the most recently served master
//     grant      out  NUM_MASTERS  one-hot winner (all zero when req is zero)
//     grant_idx  out  IDX_W        binary index of the winner
//   ARB_MODE ARB_RR scans upward from last_grant+1 with wrap-around;
//   ARB_FIXED picks the lowest-index requester.
module bus_arb_picker
  import bus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ARB_MODE    = ARB_RR,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx
);

  // Both scans run from lowest to highest priority so the last hit wins,
  // which avoids a separate "found" flag.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    if (ARB_MODE == ARB_RR) begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        cand = int'(last_grant) + k;
        if (cand >= NUM_MASTERS) begin
          cand = cand - NUM_MASTERS;
        end
        cand_idx = IDX_W'(cand);
        if (req[cand_idx]) begin
          grant           = '0;
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
        end
      end
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        cand_idx = IDX_W'(i);
        if (req[cand_idx]) begin
          grant           = '0;
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   N-master to 1-slave memory bus arbiter with request/acknowledge
//   handshake. One transaction outstanding at a time; one idle bus cycle
//   between transactions.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     m_req_i      per-master request
//     m_we_i       per-master write enable
//     m_addr_i     packed addresses, master i at [i*ADDR_W +: ADDR_W]
//     m_wdata_i    packed write data, master i at [i*DATA_W +: DATA_W]
//     m_ack_o      one-cycle one-hot completion pulse
//     m_rdata_o    read data, valid while m_ack_o is nonzero
//     m_hold_o     stall request per master (req & ~ack)
//     s_req_o, s_we_o, s_addr_o, s_wdata_o   slave request side
//     s_ack_i, s_rdata_i                     slave completion (ack may be
//                                            combinational from s_req_o)
//     err_o        timeout pulse
//   Optional feature macro BUS_ARB_TIMEOUT_EN: when defined, a BUSY phase
//   lasting TIMEOUT_CYC cycles without s_ack_i is force-completed with
//   m_rdata_o = 0 and err_o = 1. When undefined, err_o is tied to 0.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = ARB_RR,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic [NUM_MASTERS-1:0]        m_hold_o,
  output logic                          s_req_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  input  logic                          s_ack_i,
  input  logic [DATA_W-1:0]             s_rdata_i,
  output logic                          err_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYC < 1 ||
      (ARB_MODE != ARB_RR && ARB_MODE != ARB_FIXED)) begin : g_cfg_check
    $error("bus_arbiter: unsupported parameter set");
  end

  arb_state_t             state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       grant_idx_q;
  logic [NUM_MASTERS-1:0] grant_oh_q;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   timeout;

  bus_arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .ARB_MODE    (ARB_MODE)
  ) u_picker (
    .req        (m_req_i),
    .last_grant (last_grant),
    .grant      (pick_oh),
    .grant_idx  (pick_idx)
  );

  assign m_hold_o = m_req_i & ~m_ack_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IDX_W'(NUM_MASTERS - 1);
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      s_req_o     <= 1'b0;
      s_we_o      <= 1'b0;
      s_addr_o    <= '0;
      s_wdata_o   <= '0;
      m_ack_o     <= '0;
      m_rdata_o   <= '0;
    end else begin
      case (state)
        // Arbitrate and launch the winner's transfer toward the slave.
        IDLE: begin
          m_ack_o <= '0;
          if (m_req_i != '0) begin
            grant_idx_q <= pick_idx;
            grant_oh_q  <= pick_oh;
            s_req_o     <= 1'b1;
            s_we_o      <= m_we_i[pick_idx];
            s_addr_o    <= m_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
            s_wdata_o   <= m_wdata_i[int'(pick_idx)*DATA_W +: DATA_W];
            state       <= BUSY;
          end
        end
        // Slave side held stable until acknowledged (or timed out).
        BUSY: begin
          if (s_ack_i) begin
            m_rdata_o  <= s_rdata_i;
            m_ack_o    <= grant_oh_q;
            last_grant <= grant_idx_q;
            s_req_o    <= 1'b0;
            state      <= RESP;
          end else if (timeout) begin
            m_rdata_o  <= '0;
            m_ack_o    <= grant_oh_q;
            last_grant <= grant_idx_q;
            s_req_o    <= 1'b0;
            state      <= RESP;
          end
        end
        // Single ack cycle toward the granted master.
        RESP: begin
          m_ack_o <= '0;
          state   <= IDLE;
        end
        default: begin
          m_ack_o <= '0;
          s_req_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;

  // Fires in the BUSY cycle whose increment would bring the count to
  // TIMEOUT_CYC; a coincident s_ack_i takes precedence.
  assign timeout = (state == BUSY) && !s_ack_i &&
                   (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_o  <= 1'b0;
    end else begin
      err_o <= timeout;
      if (state == IDLE) begin
        to_cnt <= '0;
      end else if (state == BUSY && !s_ack_i) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Scoreboard bench for bus_arbiter. Two instances: u_rr (round-robin,
//   4 masters, behavioural slave with programmable wait states) and u_fp
//   (fixed priority, 4 masters, zero-wait slave). Expected completions are
//   queued when a request is driven and popped when an ack appears.
module tb_bus_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // round-robin instance signals
  logic [NM-1:0]    m_req, m_we, m_ack, m_hold;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata;
  logic             s_req, s_we, s_ack, err;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata, s_rdata;

  // fixed-priority instance signals
  logic [NM-1:0]    fp_m_req, fp_m_we, fp_m_ack, fp_m_hold;
  logic [NM*AW-1:0] fp_m_addr;
  logic [NM*DW-1:0] fp_m_wdata;
  logic [DW-1:0]    fp_m_rdata;
  logic             fp_s_req, fp_s_we, fp_s_ack, fp_err;
  logic [AW-1:0]    fp_s_addr;
  logic [DW-1:0]    fp_s_wdata, fp_s_rdata;

  bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYC(TO)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_ack_o(m_ack), .m_rdata_o(m_rdata), .m_hold_o(m_hold),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_ack_i(s_ack), .s_rdata_i(s_rdata), .err_o(err)
  );

  bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYC(TO)
  ) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(fp_m_req), .m_we_i(fp_m_we), .m_addr_i(fp_m_addr), .m_wdata_i(fp_m_wdata),
    .m_ack_o(fp_m_ack), .m_rdata_o(fp_m_rdata), .m_hold_o(fp_m_hold),
    .s_req_o(fp_s_req), .s_we_o(fp_s_we), .s_addr_o(fp_s_addr), .s_wdata_o(fp_s_wdata),
    .s_ack_i(fp_s_ack), .s_rdata_i(fp_s_rdata), .err_o(fp_err)
  );

  // slave for u_rr: acks when it has seen s_req for sl_wait prior cycles
  int unsigned   sl_cnt = 0;
  int unsigned   sl_wait;
  logic          sl_mute, sl_fixed;
  logic [DW-1:0] sl_rdata;
  always @(posedge clk) sl_cnt <= (s_req && !s_ack) ? sl_cnt + 1 : 0;
  assign s_ack   = s_req && !sl_mute && (sl_cnt == sl_wait);
  assign s_rdata = sl_fixed ? sl_rdata : ~s_addr;

  // slave for u_fp: zero-wait
  assign fp_s_ack   = fp_s_req;
  assign fp_s_rdata = ~fp_s_addr;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ack(input bit on_fp, input int idx, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = on_fp ? fp_m_ack[idx] : m_ack[idx];
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // scoreboard pop side
  always @(negedge clk) begin : mon
    exp_t          e;
    logic [NM-1:0] oh;
    if (m_ack != '0) begin
      if (q_rr.size() == 0) begin
        chk("rr_unexpected_ack", 64'(m_ack), 64'd0);
      end else begin
        e = q_rr.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        chk("rr_ack_onehot", 64'(m_ack), 64'(oh));
        chk("rr_rdata", 64'(m_rdata), 64'(e.rdata));
        chk("rr_err", 64'(err), 64'(e.err));
      end
    end
    if (fp_m_ack != '0) begin
      if (q_fp.size() == 0) begin
        chk("fp_unexpected_ack", 64'(fp_m_ack), 64'd0);
      end else begin
        e = q_fp.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        chk("fp_ack_onehot", 64'(fp_m_ack), 64'(oh));
        chk("fp_rdata", 64'(fp_m_rdata), 64'(e.rdata));
        chk("fp_err", 64'(fp_err), 64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst_n = 1'b0;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    fp_m_req = '0; fp_m_we = '0; fp_m_addr = '0; fp_m_wdata = '0;
    sl_wait = 0; sl_mute = 1'b0; sl_fixed = 1'b0; sl_rdata = '0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_s_addr", 64'(s_addr), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_fp_s_req", 64'(fp_s_req), 64'd0);
    rst_n = 1'b1;

    // single master write, zero-wait slave
    m_req = 4'b0001; m_we = 4'b0001;
    m_addr[0 +: AW] = 32'h100; m_wdata[0 +: DW] = 32'hDEADBEEF;
    q_rr.push_back(exp_t'{idx: 0, rdata: ~32'h100, err: 1'b0});
    @(negedge clk);
    chk("wr_s_req", 64'(s_req), 64'd1);
    chk("wr_s_we", 64'(s_we), 64'd1);
    chk("wr_s_addr", 64'(s_addr), 64'h100);
    chk("wr_s_wdata", 64'(s_wdata), 64'hDEADBEEF);
    chk("wr_no_ack_yet", 64'(m_ack), 64'd0);
    chk("wr_hold", 64'(m_hold), 64'b0001);
    @(negedge clk);
    chk("wr_ack", 64'(m_ack), 64'b0001);
    chk("wr_hold_on_ack", 64'(m_hold), 64'd0);
    chk("wr_s_req_drop", 64'(s_req), 64'd0);
    m_req = '0; m_we = '0;
    @(negedge clk);
    chk("wr_ack_pulse", 64'(m_ack), 64'd0);

    // round-robin fairness after a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_addr[0 +: AW] = 32'h200; m_addr[AW +: AW] = 32'h300;
    m_we = 4'b0011; m_req = 4'b0011;
    for (int k = 0; k < 4; k++)
      q_rr.push_back(exp_t'{idx: k % 2, rdata: (k % 2 == 1) ? ~32'h300 : ~32'h200, err: 1'b0});
    @(negedge clk);
    chk("rr_first_addr", 64'(s_addr), 64'h200);
    chk("rr_hold_both", 64'(m_hold), 64'b0011);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(1'b0, k % 2, 6, "rr_ack_seen");
      if (k == 0) chk("rr_hold_m1_waits", 64'(m_hold), 64'b0010);
      if (k > 0) chk("rr_ack_gap", 64'(cyc - prev), 64'd3);
      prev = cyc;
    end
    m_req = '0; m_we = '0;
    @(negedge clk);

    // wait-state read from master 1
    sl_wait = 5; sl_fixed = 1'b1; sl_rdata = 32'h12345678;
    m_addr[AW +: AW] = 32'h400; m_req = 4'b0010;
    q_rr.push_back(exp_t'{idx: 1, rdata: 32'h12345678, err: 1'b0});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ws_s_req", 64'(s_req), 64'd1);
      chk("ws_addr_stable", 64'(s_addr), 64'h400);
      chk("ws_no_ack", 64'(m_ack), 64'd0);
    end
    @(negedge clk);
    chk("ws_ack", 64'(m_ack), 64'b0010);
    chk("ws_rdata", 64'(m_rdata), 64'h12345678);
    m_req = '0; sl_fixed = 1'b0; sl_wait = 0;
    @(negedge clk);
    chk("ws_rdata_hold", 64'(m_rdata), 64'h12345678);
    chk("ws_ack_clear", 64'(m_ack), 64'd0);

    // reset while BUSY abandons the transfer; master 0 wins afterwards
    sl_mute = 1'b1;
    m_addr[0 +: AW] = 32'h500; m_addr[AW +: AW] = 32'h510; m_addr[2*AW +: AW] = 32'h520;
    m_wdata[2*DW +: DW] = 32'hCAFEF00D; m_we = 4'b0100;
    m_req = 4'b0110;
    @(negedge clk);
    chk("rm_busy_m2", 64'(s_addr), 64'h520);
    @(negedge clk);
    rst_n = 1'b0; m_req = 4'b0111;
    @(negedge clk);
    chk("rm_s_req", 64'(s_req), 64'd0);
    chk("rm_s_we", 64'(s_we), 64'd0);
    chk("rm_s_addr", 64'(s_addr), 64'd0);
    chk("rm_s_wdata", 64'(s_wdata), 64'd0);
    chk("rm_m_ack", 64'(m_ack), 64'd0);
    chk("rm_m_rdata", 64'(m_rdata), 64'd0);
    chk("rm_err", 64'(err), 64'd0);
    rst_n = 1'b1; sl_mute = 1'b0;
    q_rr.push_back(exp_t'{idx: 0, rdata: ~32'h500, err: 1'b0});
    q_rr.push_back(exp_t'{idx: 1, rdata: ~32'h510, err: 1'b0});
    q_rr.push_back(exp_t'{idx: 2, rdata: ~32'h520, err: 1'b0});
    @(negedge clk);
    chk("rm_winner_m0", 64'(s_addr), 64'h500);
    wait_ack(1'b0, 0, 4, "rm_ack_m0");
    m_req = 4'b0110;
    wait_ack(1'b0, 1, 6, "rm_ack_m1");
    m_req = 4'b0100;
    wait_ack(1'b0, 2, 6, "rm_ack_m2");
    m_req = '0; m_we = '0;
    @(negedge clk);

`ifdef BUS_ARB_TIMEOUT_EN
    // slave never answers: forced completion after TO BUSY cycles
    sl_mute = 1'b1;
    m_addr[3*AW +: AW] = 32'h700; m_req = 4'b1000;
    q_rr.push_back(exp_t'{idx: 3, rdata: '0, err: 1'b1});
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      chk("to_busy_s_req", 64'(s_req), 64'd1);
      chk("to_busy_no_ack", 64'(m_ack), 64'd0);
      chk("to_busy_no_err", 64'(err), 64'd0);
    end
    @(negedge clk);
    chk("to_ack", 64'(m_ack), 64'b1000);
    chk("to_err", 64'(err), 64'd1);
    m_req = '0; sl_mute = 1'b0; sl_wait = TO - 1;
    @(negedge clk);
    chk("to_err_pulse", 64'(err), 64'd0);
    // slave answers in the very cycle the timeout would fire
    m_req = 4'b1000;
    q_rr.push_back(exp_t'{idx: 3, rdata: ~32'h700, err: 1'b0});
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      chk("to_race_no_ack", 64'(m_ack), 64'd0);
    end
    @(negedge clk);
    chk("to_race_ack", 64'(m_ack), 64'b1000);
    chk("to_race_err", 64'(err), 64'd0);
    m_req = '0; sl_wait = 0;
    @(negedge clk);
`endif

    // fixed priority: master 0 starves master 2 until it drops req
    fp_m_addr[0 +: AW] = 32'h1000; fp_m_addr[2*AW +: AW] = 32'h3000;
    fp_m_req = 4'b0101;
    for (int k = 0; k < 3; k++)
      q_fp.push_back(exp_t'{idx: 0, rdata: ~32'h1000, err: 1'b0});
    q_fp.push_back(exp_t'{idx: 2, rdata: ~32'h3000, err: 1'b0});
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b1, 0, 4, "fp_ack_m0");
      chk("fp_hold_m2", 64'(fp_m_hold), 64'b0100);
    end
    fp_m_req = 4'b0100;
    wait_ack(1'b1, 2, 4, "fp_ack_m2");
    fp_m_req = '0;
    repeat (2) @(negedge clk);

    chk("rr_scoreboard_drained", 64'(q_rr.size()), 64'd0);
    chk("fp_scoreboard_drained", 64'(q_fp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-master to 1-slave memory bus arbiter with a request/acknowledge handshake.
- Next-generation replacement for the core's single fixed data-memory port. IF, LSU, and future DMA/debug masters share one RAM/ROM slave through it.
- Drives per-master hold flags so the pipeline stalls cleanly while a master waits.
- Supports round-robin or fixed-priority arbitration, selected by parameter.

Parameters:
- NUM_MASTERS, 2: number of requesting masters, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, master 0 highest.
- TIMEOUT_CYC, 64: cycles allowed for the slave to acknowledge (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- m_req_i  in  NUM_MASTERS  per-master request.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_i  in  NUM_MASTERS*ADDR_W  packed addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_wdata_i  in  NUM_MASTERS*DATA_W  packed write data.
- m_ack_o  out  NUM_MASTERS  one-cycle completion pulse, one-hot.
- m_rdata_o  out  DATA_W  read data; valid while any m_ack_o bit is high.
- m_hold_o  out  NUM_MASTERS  stall request to each master.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_ack_i  in  1  slave done; may be combinational in the same cycle as s_req_o.
- s_rdata_i  in  DATA_W  slave read data, valid with s_ack_i.
- err_o  out  1  timeout pulse (tied 0 when the optional feature is off).

Behaviour:
- Reset: clk rising edge with rst_n = 0.
  - State returns to IDLE.
  - s_req_o, s_we_o, m_ack_o and err_o clear to 0.
  - s_addr_o, s_wdata_o and m_rdata_o clear to 0.
  - Round-robin pointer last_grant resets to NUM_MASTERS-1, so master 0 wins first.
  - A reset mid-transaction abandons it: no ack is issued.
- State machine states: IDLE, BUSY, RESP.
- IDLE:
  - If m_req_i is nonzero, select a winner g.
  - Latch that master's we/addr/wdata into the s_* registers, set s_req_o = 1, and go to BUSY.
  - Otherwise remain in IDLE.
- Winner selection:
  - ARB_MODE 0: first requester scanning upward from last_grant+1, wrapping modulo NUM_MASTERS.
  - ARB_MODE 1: lowest-index requester.
- BUSY:
  - s_* outputs are held stable.
  - When s_ack_i = 1: capture s_rdata_i into m_rdata_o, set m_ack_o = 1<<g, set last_grant = g, clear s_req_o, and go to RESP.
- RESP:
  - m_ack_o is high for exactly this cycle; then return to IDLE with m_ack_o = 0.
  - The next arbitration happens in IDLE, so there is one idle bus cycle between transactions.
- Latency: request sampled in cycle 0 → s_req_o high in cycle 1 → with a zero-wait slave, m_ack_o high in cycle 2.
- Master rules:
  - A master holds req/we/addr/wdata until it sees its ack.
  - If a master drops req while in BUSY, the transaction still completes and the ack is still issued.
- m_hold_o[i] = m_req_i[i] & ~m_ack_o[i] (combinational).
- m_rdata_o holds its last value outside ack cycles. For writes, m_rdata_o captures s_rdata_i regardless of its meaning.
- Only one transaction is outstanding at any time. There is no pipelining.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to BUSY and increments each BUSY cycle without s_ack_i.
  - When the counter reaches TIMEOUT_CYC, the arbiter forces completion: m_rdata_o = 0, m_ack_o = 1<<g, err_o = 1 for the RESP cycle, and go to RESP.
  - If s_ack_i coincides with the timeout, s_ack_i wins and err_o = 0.
- When undefined: there is no counter, err_o is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Shared defines/package: FSM state encodings (IDLE/BUSY/RESP), ARB_MODE codes (ARB_RR, ARB_FIXED).
- Sub-module bus_arb_picker: combinational, takes the request vector, last_grant and ARB_MODE, and returns a one-hot grant plus its index.

Test Plan:
- Single master write: NUM_MASTERS=2; master 0 writes addr 0x100, data 0xDEADBEEF; zero-wait slave → s_req_o in cycle 1 with those values; m_ack_o = 2'b01 in cycle 2.
- Round-robin fairness: masters 0 and 1 both request continuously, ARB_MODE 0 → grants alternate 0,1,0,1 with acks 3 cycles apart; m_hold_o[1] = 1 while master 0 is served.
- Fixed priority: ARB_MODE 1, masters 0 and 2 both request, NUM_MASTERS=4 → master 0 is served every time; master 2 is served only after master 0 drops req.
- Wait-state read: slave asserts s_ack_i 5 cycles after s_req_o with rdata 0x12345678 → s_addr_o stable throughout; m_rdata_o = 0x12345678 with m_ack_o the following cycle.
- Reset mid-transaction: rst_n = 0 while in BUSY → next cycle all outputs are 0, no ack is issued, and master 0 wins the next arbitration.
- Timeout (BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): slave never acks → m_ack_o and err_o pulse after 8 BUSY cycles with m_rdata_o = 0; a repeat run with s_ack_i arriving in cycle 8 gives err_o = 0.
